instruction_fetch_queue: RTL and testbench

//   Decoupling FIFO between instruction fetch and decode. Buffers fetched {pc, instruction}

---
 rtl/instruction_fetch_queue_if.sv | 28 ++
 rtl/instruction_fetch_queue.sv | 94 +++++++++
 tb/tb_instruction_fetch_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - fetch/decode handshake bundle for the instruction fetch queue
// Purpose: groups the enqueue (fetch side) and dequeue (decode side) valid/ready handshakes.
// Ports (signals):
//   enq_valid/enq_ready/enq_pc/enq_instr  fetch -> queue entry handshake
//   deq_valid/deq_ready/deq_pc/deq_instr  queue -> decode entry handshake
// Modports: slave = the queue itself, master = the fetch/decode environment.
interface instruction_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;

  modport slave (
    input  enq_valid, enq_pc, enq_instr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr
  );

  modport master (
    output enq_valid, enq_pc, enq_instr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - FIFO decoupling instruction fetch from decode
// Purpose: buffers {pc, instruction} pairs in arrival order and presents the oldest one to decode.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous clear of all entries, overrides both handshakes
//   q_if   enq/deq valid/ready handshakes and payloads (slave modport)
//   count  number of occupied entries, 0..DEPTH
module instruction_fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int XLEN   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  instruction_fetch_queue_if.slave    q_if,
  output logic [ADDR_W:0]             count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [XLEN-1:0]   pc_mem_q    [DEPTH];
  logic [XLEN-1:0]   pc_mem_d    [DEPTH];
  logic [XLEN-1:0]   instr_mem_q [DEPTH];
  logic [XLEN-1:0]   instr_mem_d [DEPTH];

  logic enq_ready, deq_valid, enq_fire, deq_fire;

  // Readiness depends only on registered count and flush, so deq_ready
  // never reaches enq_ready combinationally; a deq frees a slot next cycle.
  always_comb begin
    enq_ready = (count_q != FULL_CNT) && !flush;
    deq_valid = (count_q != '0) && !flush;
    enq_fire  = q_if.enq_valid && enq_ready;
    deq_fire  = deq_valid && q_if.deq_ready;

    q_if.enq_ready = enq_ready;
    q_if.deq_valid = deq_valid;
    // Storage is not reset, so the payload is masked whenever nothing is valid.
    q_if.deq_pc    = deq_valid ? pc_mem_q[rd_ptr_q]    : '0;
    q_if.deq_instr = deq_valid ? instr_mem_q[rd_ptr_q] : '0;
    count          = count_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        pc_mem_d[wr_ptr_q]    = q_if.enq_pc;
        instr_mem_d[wr_ptr_q] = q_if.enq_instr;
        wr_ptr_d              = wr_ptr_q + ADDR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - scoreboard bench for instruction_fetch_queue
module tb_instruction_fetch_queue;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] count;

  instruction_fetch_queue_if #(.XLEN(32)) q_if ();

  instruction_fetch_queue #(.DEPTH(8), .ADDR_W(3), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .q_if  (q_if),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests_run = 0;
  int     tests_failed = 0;
  entry_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle. Entered and left at posedge+1; outputs sampled on the negedge.
  task automatic step(input logic ev, input logic [31:0] pc, input logic [31:0] instr,
                      input logic dr, input logic fl);
    logic   exp_enq_ready, exp_deq_valid;
    entry_t e;
    q_if.enq_valid = ev;
    q_if.enq_pc    = pc;
    q_if.enq_instr = instr;
    q_if.deq_ready = dr;
    flush          = fl;
    @(negedge clk);
    exp_enq_ready = (sb.size() != DEPTH) && !fl;
    exp_deq_valid = (sb.size() != 0) && !fl;
    check("enq_ready", 64'(q_if.enq_ready), 64'(exp_enq_ready));
    check("deq_valid", 64'(q_if.deq_valid), 64'(exp_deq_valid));
    check("count", 64'(count), 64'(sb.size()));
    if (exp_deq_valid) begin
      check("deq_pc", 64'(q_if.deq_pc), 64'(sb[0].pc));
      check("deq_instr", 64'(q_if.deq_instr), 64'(sb[0].instr));
    end else begin
      check("deq_pc_zero", 64'(q_if.deq_pc), 64'd0);
      check("deq_instr_zero", 64'(q_if.deq_instr), 64'd0);
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (exp_deq_valid && dr) void'(sb.pop_front());
      if (exp_enq_ready && ev) begin
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq_rand(input logic dr);
    step(1'b1, $urandom & 32'hFFFF_FFFC, $urandom, dr, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    q_if.enq_valid = 1'b0;
    q_if.enq_pc    = '0;
    q_if.enq_instr = '0;
    q_if.deq_ready = 1'b0;

    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(q_if.deq_valid), 64'd0);
    check("rst_enq_ready", 64'(q_if.enq_ready), 64'd1);
    check("rst_deq_pc", 64'(q_if.deq_pc), 64'd0);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single entry visible one cycle after enqueue.
    step(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill to full, a 9th offer is refused, then drain in order.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h1000 + 32'(i) * 4, 32'hA000 + 32'(i), 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd8);
    step(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Steady state at count=3 with simultaneous enq and deq; pointers wrap.
    for (int i = 0; i < 3; i++) enq_rand(1'b0);
    for (int i = 0; i < 10; i++) enq_rand(1'b1);
    check("steady_count", 64'(count), 64'd3);

    // Flush at count=5 with an enq offered; next entry after flush comes out first.
    for (int i = 0; i < 2; i++) enq_rand(1'b0);
    step(1'b1, 32'h300, 32'h1111, 1'b1, 1'b1);
    check("post_flush_count", 64'(count), 64'd0);
    step(1'b1, 32'h200, 32'h0000_0013, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset between edges at count=4.
    for (int i = 0; i < 4; i++) enq_rand(1'b0);
    check("pre_reset_count", 64'(count), 64'd4);
    q_if.enq_valid = 1'b0;
    q_if.deq_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_deq_valid", 64'(q_if.deq_valid), 64'd0);
    check("async_rst_deq_instr", 64'(q_if.deq_instr), 64'd0);
    sb.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full queue: deq and enq together -> only deq fires; enq lands next cycle.
    for (int i = 0; i < 8; i++) enq_rand(1'b0);
    step(1'b1, 32'h4000, 32'h4444, 1'b1, 1'b0);
    check("full_simul_count", 64'(count), 64'd7);
    step(1'b1, 32'h4000, 32'h4444, 1'b0, 1'b0);
    check("full_refill_count", 64'(count), 64'd8);
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
